// File: rtl/servant_uart_tx_if.sv
// Wishbone-style single-cycle responder bus used by servant peripherals.
// The master drives the request; the slave returns registered read data and a
// one-cycle acknowledge.
interface servant_uart_tx_if;
   logic [31:0] adr;
   logic [31:0] dat;
   logic        we;
   logic        cyc;
   logic [31:0] rdt;
   logic        ack;

   modport master (
      output adr,
      output dat,
      output we,
      output cyc,
      input  rdt,
      input  ack
   );

   modport slave (
      input  adr,
      input  dat,
      input  we,
      input  cyc,
      output rdt,
      output ack
   );
endinterface

// File: rtl/servant_uart_tx.sv
// UART transmitter peripheral for the servant bus.
// The CPU writes bytes into a small circular FIFO; a serial engine pops them
// and shifts each out as an 8N1 frame (start, 8 data bits LSB first, stop).
// Address bit 2 selects DATA (0) or STATUS (1); all other address bits are
// ignored.
module servant_uart_tx #(
   parameter int CLK_DIV = 868,
   parameter int AW_FIFO = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   servant_uart_tx_if.slave wb,
   output logic             tx
);

   localparam int DEPTH = 2 ** AW_FIFO;
   localparam int BW    = $clog2(CLK_DIV);

   localparam logic [BW-1:0]    BAUD_MAX  = BW'(CLK_DIV - 1);
   localparam logic [AW_FIFO:0] DEPTH_CNT = (AW_FIFO + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   // Bus side
   logic        ack_reg;
   logic [31:0] rdt_reg;
   logic        overflow_reg;
   logic        req;
   logic        data_wr;
   logic        status_rd;
   logic [31:0] status;
   logic [3:0]  level;

   // FIFO
   logic [7:0]         mem [DEPTH];
   logic [AW_FIFO-1:0] wr_ptr_reg;
   logic [AW_FIFO-1:0] rd_ptr_reg;
   logic [AW_FIFO:0]   count_reg;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;

   // Serial engine
   state_t        state_reg, state_next;
   logic [BW-1:0] baud_reg, baud_next;
   logic [2:0]    bit_reg, bit_next;
   logic          tx_reg, tx_next;
   logic [7:0]    shift_reg;
   logic          shift_en;
   logic          busy;

   // Only address bit 2 and the low data byte carry meaning.
   logic unused_bits;
   assign unused_bits = ^{wb.adr[31:3], wb.adr[1:0], wb.dat[31:8]};

   // A request is taken only while no ack is outstanding, so a held cyc is
   // serviced every second cycle.
   assign req       = wb.cyc & ~ack_reg;
   assign data_wr   = req & wb.we & ~wb.adr[2];
   assign status_rd = req & ~wb.we & wb.adr[2];

   // Full is judged on the current count, before any same-cycle pop.
   assign full  = (count_reg == DEPTH_CNT);
   assign empty = (count_reg == '0);
   assign push  = data_wr & ~full;
   assign busy  = (state_reg != IDLE);
   assign level = 4'(count_reg);

   assign status = {16'b0, 4'b0, level, 4'b0, overflow_reg, busy, empty, full};

   assign wb.ack = ack_reg;
   assign wb.rdt = rdt_reg;
   assign tx     = tx_reg;

   // Bus responder: one-cycle ack, read data valid only alongside ack,
   // sticky overflow cleared by a STATUS read.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ack_reg      <= 1'b0;
         rdt_reg      <= 32'd0;
         overflow_reg <= 1'b0;
      end else begin
         ack_reg <= req;
         rdt_reg <= status_rd ? status : 32'd0;
         if (data_wr && full) begin
            overflow_reg <= 1'b1;
         end else if (status_rd) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the depth.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // FIFO storage with a registered read port that feeds the shift register
   // directly; the shift register then moves right one bit per data bit.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wb.dat[7:0];
      end
      if (pop) begin
         shift_reg <= mem[rd_ptr_reg];
      end else if (shift_en) begin
         shift_reg <= {1'b0, shift_reg[7:1]};
      end
   end

   // Serial engine state register; reset drops any frame in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         tx_reg    <= tx_next;
      end
   end

   // Serial engine next state: each non-idle state lasts CLK_DIV cycles per
   // bit; the line value for the next bit is set on the edge that advances.
   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      tx_next    = tx_reg;
      pop        = 1'b0;
      shift_en   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               tx_next    = 1'b0;
               baud_next  = BAUD_MAX;
               state_next = START;
            end
         end
         START: begin
            if (baud_reg == '0) begin
               baud_next  = BAUD_MAX;
               tx_next    = shift_reg[0];
               bit_next   = 3'd0;
               state_next = DATA;
            end else begin
               baud_next = baud_reg - 1'b1;
            end
         end
         DATA: begin
            if (baud_reg == '0) begin
               baud_next = BAUD_MAX;
               if (bit_reg == 3'd7) begin
                  tx_next    = 1'b1;
                  state_next = STOP;
               end else begin
                  tx_next  = shift_reg[1];
                  shift_en = 1'b1;
                  bit_next = bit_reg + 3'd1;
               end
            end else begin
               baud_next = baud_reg - 1'b1;
            end
         end
         STOP: begin
            if (baud_reg == '0) begin
               baud_next  = BAUD_MAX;
               state_next = IDLE;
            end else begin
               baud_next = baud_reg - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_servant_uart_tx.sv
// Bench for servant_uart_tx: bus transactions push expected bytes into a
// queue; a line monitor decodes every completed UART frame and compares it
// with the queue head.
module tb_servant_uart_tx;

   localparam int          CLK_DIV  = 4;
   localparam logic [31:0] ADR_DATA = 32'h0000_0000;
   localparam logic [31:0] ADR_STAT = 32'h0000_0004;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx;

   int checks    = 0;
   int failures  = 0;
   int rx_frames = 0;
   int rst_edges = 0;

   logic [7:0] exp_q[$];

   servant_uart_tx_if bus ();

   servant_uart_tx #(
      .CLK_DIV(CLK_DIV),
      .AW_FIFO(3)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .wb   (bus),
      .tx   (tx)
   );

   always #5 clk = ~clk;

   // Reset edges are counted so the monitor can discard a frame cut by reset.
   always @(posedge clk) begin
      if (rst) rst_edges <= rst_edges + 1;
   end

   // Line monitor: find a start bit, sample mid-bit, compare with the queue.
   always begin : uart_monitor
      logic [7:0] data;
      logic       stop_bit;
      logic [7:0] exp;
      int         r0;
      @(negedge clk);
      if (tx === 1'b0 && !rst) begin
         r0 = rst_edges;
         @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) @(negedge clk);
            data[i] = tx;
         end
         repeat (CLK_DIV) @(negedge clk);
         stop_bit = tx;
         if (rst_edges == r0) begin
            rx_frames++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL uart_unexpected_frame got=%02h expected=none", data);
            end else begin
               exp = exp_q.pop_front();
               if (data !== exp || stop_bit !== 1'b1) begin
                  failures++;
                  $display("FAIL uart_frame got=%02h stop=%b expected=%02h stop=1",
                           data, stop_bit, exp);
               end else begin
                  $display("uart rx byte=%02h", data);
               end
            end
         end
      end
   end

   // Caller is positioned just after a rising edge.
   task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input bit keep, output logic [31:0] rdata, output bit acked);
      bus.adr = adr;
      bus.we  = we;
      bus.dat = dat;
      bus.cyc = 1'b1;
      acked   = 1'b0;
      for (int n = 0; n < 8 && !acked; n++) begin
         @(posedge clk);
         #1;
         if (bus.ack === 1'b1) acked = 1'b1;
      end
      rdata = bus.rdt;
      if (!keep) bus.cyc = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input bit keep);
      logic [31:0] r;
      bit          ok;
      wb_cycle(adr, 1'b1, dat, keep, r, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL wb_write_ack got=timeout expected=ack adr=%h", adr);
      end else begin
         $display("wb write adr=%h dat=%h", adr, dat);
      end
   endtask

   task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdata);
      bit ok;
      wb_cycle(adr, 1'b0, 32'd0, 1'b0, rdata, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL wb_read_ack got=timeout expected=ack adr=%h", adr);
      end else begin
         $display("wb read adr=%h rdt=%h", adr, rdata);
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got=%0d_pending expected=0_pending", name, exp_q.size());
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      rst     = 1'b1;
      bus.cyc = 1'b0;
      bus.we  = 1'b0;
      bus.adr = '0;
      bus.dat = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (tx !== 1'b1) begin
         failures++;
         $display("FAIL reset_tx got=%b expected=1", tx);
      end
      checks++;
      if (bus.ack !== 1'b0) begin
         failures++;
         $display("FAIL reset_ack got=%b expected=0", bus.ack);
      end
      checks++;
      if (bus.rdt !== 32'd0) begin
         failures++;
         $display("FAIL reset_rdt got=%h expected=00000000", bus.rdt);
      end
      wb_read(ADR_STAT, r);
      checks++;
      if (r !== 32'h0000_0002) begin
         failures++;
         $display("FAIL reset_status got=%h expected=00000002", r);
      end
      wb_read(ADR_DATA, r);
      checks++;
      if (r !== 32'h0000_0000) begin
         failures++;
         $display("FAIL data_read got=%h expected=00000000", r);
      end
   endtask

   task automatic test_single_byte();
      logic [7:0]  v = 8'hA5;
      logic        e;
      logic [31:0] r;
      exp_q.push_back(v);
      wb_write(ADR_DATA, 32'hFFFF_FFA5 & 32'h0000_00A5, 1'b0);
      checks++;
      if (tx !== 1'b1) begin
         failures++;
         $display("FAIL single_tx_at_ack got=%b expected=1", tx);
      end
      for (int c = 0; c < 10 * CLK_DIV; c++) begin
         @(posedge clk);
         #1;
         if (c < CLK_DIV) e = 1'b0;
         else if (c < 9 * CLK_DIV) e = v[(c - CLK_DIV) / CLK_DIV];
         else e = 1'b1;
         checks++;
         if (tx !== e) begin
            failures++;
            $display("FAIL single_bit_timing cycle=%0d got=%b expected=%b", c, tx, e);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      wb_read(ADR_STAT, r);
      checks++;
      if (r !== 32'h0000_0002) begin
         failures++;
         $display("FAIL single_status_after got=%h expected=00000002", r);
      end
      wait_drain("single");
   endtask

   task automatic test_fill_overflow();
      logic [31:0] r;
      logic [7:0]  b;
      for (int i = 0; i < 10; i++) begin
         b = 8'h30 + 8'(i);
         if (i < 9) exp_q.push_back(b);
         wb_write(ADR_DATA, {24'h0, b}, i < 9);
      end
      wb_read(ADR_STAT, r);
      checks++;
      if (r !== 32'h0000_080D) begin
         failures++;
         $display("FAIL fill_status got=%h expected=0000080d", r);
      end
      checks++;
      if (r[3] !== 1'b1) begin
         failures++;
         $display("FAIL fill_overflow_bit got=%b expected=1", r[3]);
      end
      checks++;
      if (r[11:8] !== 4'd8) begin
         failures++;
         $display("FAIL fill_level got=%0d expected=8", r[11:8]);
      end
      wb_read(ADR_STAT, r);
      checks++;
      if (r !== 32'h0000_0805) begin
         failures++;
         $display("FAIL overflow_clear got=%h expected=00000805", r);
      end
      wait_drain("fill");
   endtask

   task automatic test_wrap();
      logic [7:0] b;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            wb_write(ADR_DATA, {24'h0, b}, i < 4);
         end
         wait_drain("wrap");
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] r;
      int          frames0;
      int          lows = 0;
      exp_q.push_back(8'h35);
      wb_write(ADR_DATA, 32'h0000_0035, 1'b0);
      exp_q.push_back(8'h77);
      wb_write(ADR_DATA, 32'h0000_0077, 1'b0);
      repeat (16) @(posedge clk);
      #1;
      checks++;
      if (tx !== 1'b0) begin
         failures++;
         $display("FAIL midframe_bit3 got=%b expected=0", tx);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (tx !== 1'b1) begin
         failures++;
         $display("FAIL midframe_reset_tx got=%b expected=1", tx);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      frames0 = rx_frames;
      wb_read(ADR_STAT, r);
      checks++;
      if (r !== 32'h0000_0002) begin
         failures++;
         $display("FAIL midframe_status got=%h expected=00000002", r);
      end
      for (int c = 0; c < 60; c++) begin
         @(posedge clk);
         #1;
         if (tx !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin
         failures++;
         $display("FAIL midframe_residual got=%0d_low_cycles expected=0", lows);
      end
      checks++;
      if (rx_frames != frames0) begin
         failures++;
         $display("FAIL midframe_frames got=%0d expected=%0d", rx_frames, frames0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b [4];
      logic       e;
      int         k = 0;
      int         frames0 = rx_frames;
      b[0] = 8'h11; b[1] = 8'h82; b[2] = 8'hC3; b[3] = 8'hEE;
      bus.adr = ADR_DATA;
      bus.we  = 1'b1;
      bus.dat = {24'h0, b[0]};
      bus.cyc = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         e = (c % 2 == 1);
         checks++;
         if (bus.ack !== e) begin
            failures++;
            $display("FAIL b2b_ack cycle=%0d got=%b expected=%b", c, bus.ack, e);
         end
         checks++;
         if (bus.rdt !== 32'd0) begin
            failures++;
            $display("FAIL b2b_rdt cycle=%0d got=%h expected=00000000", c, bus.rdt);
         end
         if (bus.ack === 1'b1 && k < 3) begin
            exp_q.push_back(b[k]);
            $display("wb write adr=%h dat=%h (held cyc)", bus.adr, bus.dat);
            k++;
            bus.dat = {24'h0, b[k]};
         end
      end
      bus.cyc = 1'b0;
      checks++;
      if (k != 3) begin
         failures++;
         $display("FAIL b2b_accepted got=%0d expected=3", k);
      end
      wait_drain("b2b");
      checks++;
      if (rx_frames - frames0 != 3) begin
         failures++;
         $display("FAIL b2b_frames got=%0d expected=3", rx_frames - frames0);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_fill_overflow();
      test_wrap();
      test_reset_mid_frame();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
